// File: rtl/recuperador_memoria.sv
`default_nettype none
// ============================================================================
// Module      : recuperador_memoria
// Description : Keeps a private history of the results written through the
//               ULA memory-store path and recalls a selected past value as
//               an operand for the ULA input mux, under a valid/accept
//               handshake.
//
//   Build option RECUPERADOR_HISTORICO_EN:
//     defined   -> ring buffer of PROFUNDIDADE entries, 'anterior' steps
//                  the selection towards older entries.
//     undefined -> single register; 'anterior' ignored, 'indice' tied to 0,
//                  'contagem' is 0 or 1.
//
//   Ports:
//     clk, rst           clock (rising edge), synchronous active-high reset
//     carregar_memoria   store strobe, writes valor_entrada into history
//     valor_entrada[7:0] result being stored
//     recuperar          recall request (sampled in OCIOSO only)
//     anterior           select one entry older (sampled in OCIOSO only)
//     limpar             erase history and abort any recall (top priority)
//     aceito             consumer accepts operando
//     operando[7:0]      recalled value, stable while operando_valido
//     operando_valido    operando held and valid
//     ocupado            FSM busy with a recall
//     contagem[3:0]      number of valid entries
//     indice[2:0]        selected entry offset, 0 = newest
//     erro_vazio         one-cycle pulse: recall requested on empty history
//
// Revision    : 1.0 - initial release
// ============================================================================
module recuperador_memoria #(
    parameter int PROFUNDIDADE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       carregar_memoria,
    input  logic [7:0] valor_entrada,
    input  logic       recuperar,
    input  logic       anterior,
    input  logic       limpar,
    input  logic       aceito,
    output logic [7:0] operando,
    output logic       operando_valido,
    output logic       ocupado,
    output logic [3:0] contagem,
    output logic [2:0] indice,
    output logic       erro_vazio
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox_estado;
    logic       r_fase;
    logic [7:0] r_operando;
    logic       r_erro;

    logic [7:0] w_leitura;
    logic [3:0] w_contagem;
    logic [2:0] w_indice;
    logic       w_escrita;
    logic       w_aceite;

    // A clear in the same cycle discards the write.
    assign w_escrita = carregar_memoria && !limpar;
    assign w_aceite  = (r_estado == ENTREGA) && aceito;

`ifdef RECUPERADOR_HISTORICO_EN
    localparam int c_PROF = PROFUNDIDADE;
    localparam int c_AW   = $clog2(c_PROF);

    logic [7:0]      r_mem [c_PROF];
    logic [c_AW-1:0] r_wp;
    logic [3:0]      r_contagem;
    logic [2:0]      r_indice;
    logic [c_AW-1:0] w_end_leitura;
    logic            w_passo;

    // Offset k lives at (wp-1-k); the c_AW-bit subtraction wraps naturally
    // because the depth is a power of two.
    assign w_end_leitura = r_wp - c_AW'(1) - r_indice[c_AW-1:0];
    assign w_leitura     = r_mem[w_end_leitura];

    // A step is discarded when a recall is requested in the same cycle, and
    // it saturates at the oldest valid entry.
    assign w_passo = (r_estado == OCIOSO) && anterior && !recuperar &&
                     (r_contagem != 4'd0) &&
                     (({1'b0, r_indice} + 4'd1) < r_contagem);

    always_ff @(posedge clk) begin
        if (w_escrita) begin
            r_mem[r_wp] <= valor_entrada;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            r_wp       <= '0;
            r_contagem <= 4'd0;
            r_indice   <= 3'd0;
        end else if (w_escrita) begin
            r_wp     <= r_wp + c_AW'(1);
            r_indice <= 3'd0;
            if (r_contagem != 4'(c_PROF)) begin
                r_contagem <= r_contagem + 4'd1;
            end
        end else if (w_aceite) begin
            r_indice <= 3'd0;
        end else if (w_passo) begin
            r_indice <= r_indice + 3'd1;
        end
    end

    assign w_contagem = r_contagem;
    assign w_indice   = r_indice;
`else
    logic [7:0] r_mem_unico;
    logic       r_tem_valor;
    logic       w_unused;

    // Navigation and depth have no meaning with a single register.
    assign w_unused = anterior & (PROFUNDIDADE != 0);

    always_ff @(posedge clk) begin
        if (w_escrita) begin
            r_mem_unico <= valor_entrada;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            r_tem_valor <= 1'b0;
        end else if (w_escrita) begin
            r_tem_valor <= 1'b1;
        end
    end

    assign w_leitura  = r_mem_unico;
    assign w_contagem = {3'b000, r_tem_valor};
    assign w_indice   = 3'd0;
`endif

    // ------------------------------------------------------------------
    // Recall FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (recuperar && (w_contagem != 4'd0)) begin
                    w_prox_estado = BUSCA;
                end
            end
            BUSCA: begin
                if (r_fase) begin
                    w_prox_estado = ENTREGA;
                end
            end
            ENTREGA: begin
                if (aceito) begin
                    w_prox_estado = OCIOSO;
                end
            end
            default: w_prox_estado = OCIOSO;
        endcase
        if (limpar) begin
            w_prox_estado = OCIOSO;
        end
    end

    // BUSCA spans two cycles: the first registers the selected entry into
    // operando, the second presents it, so the operand has been stable for a
    // full cycle before operando_valido rises.
    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            r_fase <= 1'b0;
        end else if (r_estado == BUSCA) begin
            r_fase <= ~r_fase;
        end else begin
            r_fase <= 1'b0;
        end
    end

    // Read uses the registered history, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_operando <= 8'h00;
        end else if (!limpar && (r_estado == BUSCA) && !r_fase) begin
            r_operando <= w_leitura;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= !limpar && (r_estado == OCIOSO) && recuperar &&
                      (w_contagem == 4'd0);
        end
    end

    assign operando        = r_operando;
    assign operando_valido = (r_estado == ENTREGA);
    assign ocupado         = (r_estado != OCIOSO);
    assign contagem        = w_contagem;
    assign indice          = w_indice;
    assign erro_vazio      = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_recuperador_memoria.sv
`default_nettype none
// ============================================================================
// Module      : tb_recuperador_memoria
// Description : Directed bench for recuperador_memoria. Stimulus pushes the
//               expected operand into a scoreboard queue; a monitor compares
//               operando against the queue head on every valid cycle and
//               pops on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recuperador_memoria;

    logic       clk = 1'b0;
    logic       rst;
    logic       carregar_memoria;
    logic [7:0] valor_entrada;
    logic       recuperar;
    logic       anterior;
    logic       limpar;
    logic       aceito;
    logic [7:0] operando;
    logic       operando_valido;
    logic       ocupado;
    logic [3:0] contagem;
    logic [2:0] indice;
    logic       erro_vazio;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    recuperador_memoria #(.PROFUNDIDADE(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .carregar_memoria (carregar_memoria),
        .valor_entrada    (valor_entrada),
        .recuperar        (recuperar),
        .anterior         (anterior),
        .limpar           (limpar),
        .aceito           (aceito),
        .operando         (operando),
        .operando_valido  (operando_valido),
        .ocupado          (ocupado),
        .contagem         (contagem),
        .indice           (indice),
        .erro_vazio       (erro_vazio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, act, exp);
        end
    endtask

    // Monitor: inputs are driven right at the falling edge, so 2 ns later
    // both the outputs and the aceito about to be sampled are settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (operando_valido === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL operando_inesperado: got 0x%0h, expected no valid", operando);
                end else begin
                    chk("operando", int'(operando), int'(sb[0]));
                    if (aceito) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic escrever(input logic [7:0] v);
        carregar_memoria = 1'b1;
        valor_entrada    = v;
        @(negedge clk);
        carregar_memoria = 1'b0;
    endtask

    task automatic passo_anterior();
        anterior = 1'b1;
        @(negedge clk);
        anterior = 1'b0;
    endtask

    task automatic pulso_limpar();
        limpar = 1'b1;
        @(negedge clk);
        limpar = 1'b0;
    endtask

    task automatic iniciar_recall(input logic [7:0] e);
        sb.push_back(e);
        recuperar = 1'b1;
        @(negedge clk);                 // edge N
        recuperar = 1'b0;
        chk("ocupado_N", int'(ocupado), 1);
        chk("valido_N", int'(operando_valido), 0);
        @(negedge clk);                 // edge N+1
        chk("valido_N1", int'(operando_valido), 0);
        @(negedge clk);                 // edge N+2
        chk("valido_N2", int'(operando_valido), 1);
    endtask

    task automatic aceitar();
        @(negedge clk);
        @(negedge clk);
        aceito = 1'b1;
        @(negedge clk);                 // edge M
        aceito = 1'b0;
        chk("valido_pos_aceito", int'(operando_valido), 0);
        chk("ocupado_pos_aceito", int'(ocupado), 0);
        chk("indice_pos_aceito", int'(indice), 0);
    endtask

    task automatic recall_vazio();
        recuperar = 1'b1;
        @(negedge clk);
        recuperar = 1'b0;
        chk("erro_vazio_pulso", int'(erro_vazio), 1);
        chk("erro_ocupado", int'(ocupado), 0);
        chk("erro_valido", int'(operando_valido), 0);
        @(negedge clk);
        chk("erro_vazio_fim", int'(erro_vazio), 0);
        chk("erro_valido2", int'(operando_valido), 0);
    endtask

    initial begin
        rst = 1'b1;
        carregar_memoria = 1'b0;
        valor_entrada = 8'h00;
        recuperar = 1'b0;
        anterior = 1'b0;
        limpar = 1'b0;
        aceito = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_operando", int'(operando), 8'h00);
        chk("rst_valido", int'(operando_valido), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_contagem", int'(contagem), 0);
        chk("rst_indice", int'(indice), 0);
        chk("rst_erro", int'(erro_vazio), 0);

        // Recall on empty history
        recall_vazio();

        // Newest value recall with latency and hold
        escrever(8'h11);
        escrever(8'h22);
        escrever(8'h33);
`ifdef RECUPERADOR_HISTORICO_EN
        chk("contagem_3", int'(contagem), 3);
`else
        chk("contagem_1", int'(contagem), 1);
`endif
        iniciar_recall(8'h33);
        aceitar();

`ifdef RECUPERADOR_HISTORICO_EN
        // Overwrite when full, saturating navigation
        pulso_limpar();
        chk("limpar_contagem", int'(contagem), 0);
        for (int i = 1; i <= 5; i++) escrever(8'(i * 8'h11));
        chk("contagem_sat", int'(contagem), 4);
        for (int i = 1; i <= 5; i++) begin
            passo_anterior();
            chk("indice_passo", int'(indice), (i < 3) ? i : 3);
        end
        iniciar_recall(8'h22);
        aceitar();

        // Write during ENTREGA leaves operando untouched
        pulso_limpar();
        escrever(8'h0A);
        escrever(8'h0B);
        passo_anterior();
        chk("indice_1", int'(indice), 1);
        iniciar_recall(8'h0A);
        escrever(8'hCC);
        chk("contagem_entrega", int'(contagem), 3);
        chk("valido_entrega", int'(operando_valido), 1);
        aceitar();
        iniciar_recall(8'hCC);
        aceitar();

        // Step and recall together: recall uses pre-step index
        anterior = 1'b1;
        iniciar_recall(8'hCC);
        anterior = 1'b0;
        aceitar();
        chk("indice_passo_descartado", int'(indice), 0);
`else
        // Single-register build: navigation ignored
        pulso_limpar();
        escrever(8'h01);
        escrever(8'h02);
        passo_anterior();
        chk("indice_zero", int'(indice), 0);
        chk("contagem_um", int'(contagem), 1);
        iniciar_recall(8'h02);
        chk("indice_recall", int'(indice), 0);
        aceitar();
`endif

        // Clear during ENTREGA with a simultaneous write
        escrever(8'h44);
        iniciar_recall(8'h44);
        limpar = 1'b1;
        carregar_memoria = 1'b1;
        valor_entrada = 8'h77;
        @(negedge clk);
        limpar = 1'b0;
        carregar_memoria = 1'b0;
        chk("limpar_valido", int'(operando_valido), 0);
        chk("limpar_contagem2", int'(contagem), 0);
        chk("limpar_ocupado", int'(ocupado), 0);
        sb.delete();
        recall_vazio();

        // Reset in the middle of a recall
        escrever(8'h55);
        recuperar = 1'b1;
        @(negedge clk);
        recuperar = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_meio_ocupado", int'(ocupado), 0);
        chk("rst_meio_contagem", int'(contagem), 0);
        chk("rst_meio_operando", int'(operando), 8'h00);
        @(negedge clk);
        chk("rst_meio_valido", int'(operando_valido), 0);

        chk("fila_vazia", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
